// File: rtl/kernel_pr_fifo_param.sv
// Circular-buffer stream FIFO with first-word-fall-through output, registered
// occupancy/threshold flags and sticky overflow/underflow error flags.
module kernel_pr_fifo_param #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 3,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic [ADDR_WIDTH:0]   if_count,
    output logic                  if_almost_full,
    output logic                  if_almost_empty,
    output logic                  if_overflow,
    output logic                  if_underflow
);

    generate
        if (DEPTH < 2 || DEPTH > 4096 || ADDR_WIDTH != $clog2(DEPTH)) begin : g_bad_param
            $error("kernel_pr_fifo_param: DEPTH must be 2..4096 and ADDR_WIDTH must equal clog2(DEPTH)");
        end
    endgenerate

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_AE   = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic push, pop, push_ok, pop_ok;

    assign push    = if_write & if_write_ce;
    assign pop     = if_read & if_read_ce;
    assign push_ok = push & full_n_q;
    assign pop_ok  = pop & empty_n_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push & ~full_n_q);
        unf_d    = unf_q | (pop & ~empty_n_q);

        // Explicit wrap so non-power-of-two depths never index past DEPTH-1
        if (push_ok) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;

        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;

        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != CNT_FULL);
        af_d      = (count_d >= CNT_AF);
        ae_d      = (count_d <= CNT_AE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
            af_q      <= (AF_LEVEL == 0);
            ae_q      <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Storage carries no reset; stale words are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= if_din;
    end

    assign if_dout         = mem_q[rd_ptr_q];
    assign if_empty_n      = empty_n_q;
    assign if_full_n       = full_n_q;
    assign if_count        = count_q;
    assign if_almost_full  = af_q;
    assign if_almost_empty = ae_q;
    assign if_overflow     = ovf_q;
    assign if_underflow    = unf_q;

endmodule

// File: doc/kernel_pr_fifo_param.md
Name: kernel_pr_fifo_param

Overview:
Parametrised successor to the fixed w64/d3 shift-register stream FIFOs in the PageRank kernel. It is a circular-buffer FIFO with the following properties:
- any width and any depth of 2 or more, including non-power-of-two depths;
- first-word-fall-through output;
- registered occupancy count and programmable almost-full/almost-empty flags;
- sticky overflow/underflow error flags.

It sits between kernel dataflow stages, and keeps the same if_* handshake so that it is a drop-in replacement for existing FIFO instances.

Parameters:
DATA_WIDTH, 64, width of each data word in bits.
DEPTH, 3, number of storage entries; legal range 2..4096.
ADDR_WIDTH, 2, pointer width; must equal ceil(log2(DEPTH)), checked at elaboration.
AF_LEVEL, DEPTH-1, if_almost_full asserts when count >= AF_LEVEL.
AE_LEVEL, 1, if_almost_empty asserts when count <= AE_LEVEL.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
if_empty_n  output  1  1 = head word valid on if_dout.
if_read_ce  input  1  read clock enable.
if_read  input  1  read request; the pop is if_read & if_read_ce.
if_dout  output  DATA_WIDTH  head-of-queue word (FWFT).
if_full_n  output  1  1 = space for at least one more word.
if_write_ce  input  1  write clock enable.
if_write  input  1  write request; the push is if_write & if_write_ce.
if_din  input  DATA_WIDTH  write data.
if_count  output  ADDR_WIDTH+1  registered number of stored words, 0..DEPTH.
if_almost_full  output  1  registered, count >= AF_LEVEL.
if_almost_empty  output  1  registered, count <= AE_LEVEL.
if_overflow  output  1  sticky: a push was attempted while if_full_n=0.
if_underflow  output  1  sticky: a pop was attempted while if_empty_n=0.

Behaviour:
- Reset (async assert, sync release), applied at any time including mid-operation:
  - wr_ptr=0, rd_ptr=0, count=0;
  - if_empty_n=0, if_full_n=1;
  - if_almost_empty=1, if_almost_full=(AF_LEVEL==0);
  - if_overflow=0, if_underflow=0.
  - Storage array is not reset, and its contents are discarded.
- Accept conditions:
  - push_ok = push & if_full_n.
  - pop_ok = pop & if_empty_n.
  - Requests that are not accepted are ignored and have no effect on storage or pointers.
- Storage is an array of DEPTH words.
  - On push_ok: mem[wr_ptr] <= if_din.
  - wr_ptr advances by 1 and wraps from DEPTH-1 to 0, with an explicit compare, never modulo 2^ADDR_WIDTH.
  - rd_ptr advances and wraps the same way on pop_ok.
- if_dout = mem[rd_ptr], read combinationally.
  - Valid whenever if_empty_n=1.
  - Undefined (do not check) when if_empty_n=0.
- Count update:
  - push_ok only: +1.
  - pop_ok only: -1.
  - Both or neither: unchanged.
- All status outputs are registered and computed from the next count:
  - if_empty_n = (next!=0).
  - if_full_n = (next!=DEPTH).
  - if_almost_full = (next>=AF_LEVEL).
  - if_almost_empty = (next<=AE_LEVEL).
- Latencies:
  - Write into an empty FIFO at edge N: if_empty_n=1 and if_dout=written word after edge N (one-cycle latency, same as the d3 FIFOs).
  - Pop at edge N frees space; if_full_n rises after edge N.
- Simultaneous push and pop:
  - When full: the pop is accepted; the push is rejected because if_full_n=0. Count becomes DEPTH-1 and if_overflow sets. Upstream must respect if_full_n.
  - When empty: the push is accepted; the pop is rejected and if_underflow sets. Count becomes 1.
  - Otherwise: both are accepted, count is unchanged, and both pointers advance.
- Sticky errors:
  - if_overflow sets on a push with if_full_n=0.
  - if_underflow sets on a pop with if_empty_n=0.
  - Both are cleared only by reset.
- Ordering: strict FIFO order is preserved across pointer wrap, for any DEPTH.

Test Plan:
- Reset, then push 0x11,0x22,0x33 on consecutive cycles with DEPTH=3 → if_empty_n=1 one cycle after the first push; if_full_n=0 after the third; if_count=3; if_dout=0x11.
- With DEPTH=5, AF_LEVEL=4, AE_LEVEL=1: push 12 words 1..12 while popping continuously after an initial 2-cycle lead → output sequence 1..12 exactly. Pointers wrap at 4→0; no error flags.
- With the FIFO full, assert push and pop together with if_din=0xAA → head word popped; count=DEPTH-1; 0xAA not stored; if_overflow=1 and stays 1.
- With the FIFO empty, assert push (0x5) and pop together → count=1; if_dout=0x5; if_underflow=1.
- Push only while if_read_ce=0 and if_read=1 → no pops occur and count climbs; then with if_write_ce=0, if_write=1 → count holds. Check if_almost_full/if_almost_empty toggle exactly at the thresholds.
- Assert reset asynchronously mid-stream with count=2 → all outputs take their reset values immediately, without waiting for a clock edge. After release, a push of 0x7 gives if_dout=0x7 and count=1.
